// File: rtl/alu_operand_stage_if.sv
// Bus bundle between the execute-stage operand sequencer and its environment
// (controller handshake, register-file read port, ALU inputs/outputs, results).
interface alu_operand_stage_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [2:0]       rn;
  logic [2:0]       rm;
  logic [1:0]       shift;
  logic [1:0]       aluop_in;
  logic             asel;
  logic             bsel;
  logic [WIDTH-1:0] sximm5;
  logic [2:0]       rd_num;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [1:0]       aluop;
  logic [WIDTH-1:0] alu_out;
  logic [2:0]       alu_z;
  logic [WIDTH-1:0] c_out;
  logic [2:0]       status;
  logic             done;

  // Environment side: controller, register file and ALU.
  modport master (
    output start, rn, rm, shift, aluop_in, asel, bsel, sximm5,
    output rd_data, alu_out, alu_z,
    input  ready, rd_num, ain, bin, aluop, c_out, status, done
  );

  // Operand stage side.
  modport slave (
    input  start, rn, rm, shift, aluop_in, asel, bsel, sximm5,
    input  rd_data, alu_out, alu_z,
    output ready, rd_num, ain, bin, aluop, c_out, status, done
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Multi-cycle operand fetch / execute / capture stage around a 16-bit ALU.
// Optional macro OPSTAGE_SKIP_A_EN: skip the Rn read when asel is captured high.
module alu_operand_stage #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                reset,
  alu_operand_stage_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic [2:0]       r_rm;
  logic [1:0]       r_shift;
  logic [1:0]       r_aluop;
  logic             r_asel;
  logic             r_bsel;
  logic [WIDTH-1:0] r_sximm5;
  logic [2:0]       r_rd_num;
  logic             r_ready;
  logic             r_done;

  logic [WIDTH-1:0] w_sb;

  always_comb begin
    // NOTE: default first so every path assigns w_sb and no latch is inferred.
    w_sb = r_b;
    case (r_shift)
      2'b01:   w_sb = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_sb = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_sb = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_sb = r_b;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      r_rm     <= '0;
      r_shift  <= '0;
      r_aluop  <= '0;
      r_asel   <= 1'b0;
      r_bsel   <= 1'b0;
      r_sximm5 <= '0;
      r_rd_num <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rm     <= bus.rm;
            r_shift  <= bus.shift;
            r_aluop  <= bus.aluop_in;
            r_asel   <= bus.asel;
            r_bsel   <= bus.bsel;
            r_sximm5 <= bus.sximm5;
            r_ready  <= 1'b0;
`ifdef OPSTAGE_SKIP_A_EN
            if (bus.asel) begin
              r_state  <= S_RD_B;
              r_rd_num <= bus.rm;
            end else
`endif
            begin
              r_state  <= S_RD_A;
              r_rd_num <= bus.rn;
            end
          end
        end
        S_RD_A: begin
          r_a      <= bus.rd_data;
          r_rd_num <= r_rm;
          r_state  <= S_RD_B;
        end
        S_RD_B: begin
          r_b      <= bus.rd_data;
          r_rd_num <= '0;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_c      <= bus.alu_out;
          // The ALU V flag is meaningless for the logic ops (aluop 1x).
          r_status <= {bus.alu_z[2:1], r_aluop[1] ? 1'b0 : bus.alu_z[0]};
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done   <= 1'b0;
          r_ready  <= 1'b1;
          r_rd_num <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.done   = r_done;
  assign bus.rd_num = r_rd_num;
  assign bus.aluop  = r_aluop;
  assign bus.ain    = r_asel ? '0 : r_a;
  assign bus.bin    = r_bsel ? r_sximm5 : w_sb;
  assign bus.c_out  = r_c;
  assign bus.status = r_status;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized + directed self-checking bench for alu_operand_stage; the bench
// supplies the register file and ALU and predicts results with integer math.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  logic [15:0] regs [8];

  alu_operand_stage_if #(.WIDTH(16)) bus ();

  alu_operand_stage #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = regs[bus.rd_num];

  // Environment ALU; V is deliberately driven high for the logic ops.
  always_comb begin
    logic [15:0] r;
    logic        v;
    r = '0;
    v = 1'b1;
    case (bus.aluop)
      2'b00: begin
        r = bus.ain + bus.bin;
        v = (bus.ain[15] == bus.bin[15]) && (r[15] != bus.ain[15]);
      end
      2'b01: begin
        r = bus.ain - bus.bin;
        v = (bus.ain[15] != bus.bin[15]) && (r[15] != bus.ain[15]);
      end
      2'b10:   r = bus.ain & bus.bin;
      default: r = ~bus.bin;
    endcase
    bus.alu_out = r;
    bus.alu_z   = {r == 16'h0000, r[15], v};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input logic [15:0] x);
    return (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  // Reference: operand selection, shift and ALU result from arithmetic rules.
  function automatic void model(input logic [15:0] a_reg, input logic [15:0] b_reg,
                                input logic [1:0] sh, input logic [1:0] op,
                                input logic as_v, input logic bs_v, input logic [15:0] imm,
                                output logic [15:0] ain_e, output logic [15:0] bin_e,
                                output logic [15:0] c_e, output logic [2:0] st_e);
    int bu, sbv, r;
    logic v;
    bu = int'(b_reg);
    case (sh)
      2'd0:    sbv = bu;
      2'd1:    sbv = (bu * 2) % 65536;
      2'd2:    sbv = bu / 2;
      default: sbv = bu / 2 + ((bu >= 32768) ? 32768 : 0);
    endcase
    ain_e = as_v ? 16'h0000 : a_reg;
    bin_e = bs_v ? imm : 16'(sbv);
    v = 1'b0;
    case (op)
      2'd0: begin
        r   = to_signed(ain_e) + to_signed(bin_e);
        v   = (r > 32767) || (r < -32768);
        c_e = 16'(r);
      end
      2'd1: begin
        r   = to_signed(ain_e) - to_signed(bin_e);
        v   = (r > 32767) || (r < -32768);
        c_e = 16'(r);
      end
      2'd2:    c_e = ain_e & bin_e;
      default: c_e = ~bin_e;
    endcase
    st_e = {c_e == 16'h0000, int'(c_e) >= 32768, v};
  endfunction

  // Issue one operation at a negedge in IDLE and follow it for six cycles.
  task automatic run_op(input string tag, input logic [2:0] rn_v, input logic [2:0] rm_v,
                        input logic [1:0] sh, input logic [1:0] op, input logic as_v,
                        input logic bs_v, input logic [15:0] imm, input bit poke);
    logic [15:0] ain_e, bin_e, c_e;
    logic [2:0]  st_e;
    logic [2:0]  rd_seq [7];
    logic [15:0] ain_seq [7];
    logic [15:0] bin_seq [7];
    logic        rdy_seq [7];
    int exp_lat, done_cyc, n_done;

    model(regs[rn_v], regs[rm_v], sh, op, as_v, bs_v, imm, ain_e, bin_e, c_e, st_e);
    exp_lat = 4;
`ifdef OPSTAGE_SKIP_A_EN
    if (as_v) exp_lat = 3;
`endif
    check({tag, ":ready_idle"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1; bus.rn = rn_v; bus.rm = rm_v; bus.shift = sh;
    bus.aluop_in = op; bus.asel = as_v; bus.bsel = bs_v; bus.sximm5 = imm;
    @(negedge clk);
    done_cyc = 0;
    n_done   = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      // Fields must have been captured; scramble them.
      bus.rn = 3'($urandom); bus.rm = 3'($urandom); bus.shift = 2'($urandom);
      bus.aluop_in = 2'($urandom); bus.asel = 1'($urandom); bus.bsel = 1'($urandom);
      bus.sximm5 = 16'($urandom);
      rd_seq[cyc]  = bus.rd_num;
      ain_seq[cyc] = bus.ain;
      bin_seq[cyc] = bus.bin;
      rdy_seq[cyc] = bus.ready;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
        check({tag, ":c_out_at_done"}, 32'(bus.c_out), 32'(c_e));
        check({tag, ":status_at_done"}, 32'(bus.status), 32'(st_e));
      end
      bus.start = (poke && cyc == exp_lat - 1) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, ":latency"}, 32'(done_cyc), 32'(exp_lat));
    check({tag, ":done_pulses"}, 32'(n_done), 32'd1);
    if (exp_lat == 4) begin
      check({tag, ":rd_num_a"}, 32'(rd_seq[1]), 32'(rn_v));
      check({tag, ":rd_num_b"}, 32'(rd_seq[2]), 32'(rm_v));
    end else begin
      check({tag, ":rd_num_b"}, 32'(rd_seq[1]), 32'(rm_v));
    end
    check({tag, ":rd_num_exec"}, 32'(rd_seq[exp_lat - 1]), 32'd0);
    check({tag, ":ain_exec"}, 32'(ain_seq[exp_lat - 1]), 32'(ain_e));
    check({tag, ":bin_exec"}, 32'(bin_seq[exp_lat - 1]), 32'(bin_e));
    check({tag, ":busy"}, 32'(rdy_seq[1]), 32'd0);
    check({tag, ":ready_after"}, 32'(rdy_seq[exp_lat + 1]), 32'd1);
    check({tag, ":ready_end"}, 32'(rdy_seq[6]), 32'd1);
    check({tag, ":c_out_hold"}, 32'(bus.c_out), 32'(c_e));
    check({tag, ":status_hold"}, 32'(bus.status), 32'(st_e));
  endtask

  initial begin
    int n_done;
    reset = 1'b1;
    bus.start = 1'b0; bus.rn = '0; bus.rm = '0; bus.shift = '0; bus.aluop_in = '0;
    bus.asel = 1'b0; bus.bsel = 1'b0; bus.sximm5 = '0;
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0111);
    #2;
    check("rst:ready", 32'(bus.ready), 32'd1);
    check("rst:done", 32'(bus.done), 32'd0);
    check("rst:c_out", 32'(bus.c_out), 32'd0);
    check("rst:status", 32'(bus.status), 32'd0);
    check("rst:rd_num", 32'(bus.rd_num), 32'd0);
    check("rst:aluop", 32'(bus.aluop), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    regs[1] = 16'h0005; regs[2] = 16'h0003;
    run_op("add", 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    regs[3] = 16'h0007; regs[4] = 16'h0007;
    run_op("sub_eq", 3'd3, 3'd4, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1);
    regs[5] = 16'h7FFF; regs[6] = 16'h0001;
    run_op("add_ovf", 3'd5, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    regs[7] = 16'h0001;
    run_op("mvn_lsl", 3'd1, 3'd7, 2'b01, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0);
    regs[3] = 16'h8004;
    run_op("asr", 3'd2, 3'd3, 2'b11, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b0);
    regs[0] = 16'h0010;
    run_op("imm", 3'd0, 3'd6, 2'b10, 2'b00, 1'b0, 1'b1, 16'hFFF0, 1'b1);
    run_op("and_lsr", 3'd5, 3'd3, 2'b10, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Reset during RD_B wipes a prior result and suppresses done.
    run_op("add2", 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    bus.start = 1'b1; bus.rn = 3'd5; bus.rm = 3'd6; bus.aluop_in = 2'b00;
    bus.asel = 1'b0; bus.bsel = 1'b0; bus.shift = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid:rd_num_b", 32'(bus.rd_num), 32'd6);
    reset = 1'b1;
    #1;
    check("mid:c_out", 32'(bus.c_out), 32'd0);
    check("mid:status", 32'(bus.status), 32'd0);
    check("mid:ready", 32'(bus.ready), 32'd1);
    check("mid:done", 32'(bus.done), 32'd0);
    check("mid:rd_num", 32'(bus.rd_num), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) n_done++;
    end
    check("mid:no_done", 32'(n_done), 32'd0);
    check("mid:c_out_after", 32'(bus.c_out), 32'd0);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0:       regs[i] = 16'h8000;
          1:       regs[i] = 16'h7FFF;
          default: regs[i] = 16'($urandom);
        endcase
      end
      run_op($sformatf("rnd%0d", k), 3'($urandom), 3'($urandom), 2'($urandom),
             2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Multi-cycle execute stage wrapped around the 16-bit ALU.
- Reads operands Rn and Rm from the register file over two cycles and applies the 1-bit shifter to the B operand.
- Drives the ALU inputs, then captures the ALU result into the C register and the ALU flags into the status register.
- Sits between the register file and the writeback mux; handshakes with the controller via start/ready/done.

Parameters:
WIDTH, 16, datapath width; must equal ALU width (only 16 supported).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; returns block to IDLE
start  input  1  begin operation; sampled only when ready=1
ready  output  1  high only in IDLE
rn  input  3  register number for A operand; captured at accepted start
rm  input  3  register number for B operand; captured at accepted start
shift  input  2  shifter op for B; captured at start
aluop_in  input  2  ALU op; captured at start
asel  input  1  1: ALU A input forced to 0; captured at start
bsel  input  1  1: ALU B input = sximm5; captured at start
sximm5  input  WIDTH  sign-extended immediate; captured at start
rd_num  output  3  register file read address
rd_data  input  WIDTH  register file read data (combinational from rd_num)
ain  output  WIDTH  to ALU Ain
bin  output  WIDTH  to ALU Bin
aluop  output  2  to ALU ALUop (registered field)
alu_out  input  WIDTH  from ALU out
alu_z  input  3  from ALU flags {Z,N,V}
c_out  output  WIDTH  C register
status  output  3  status register {Z,N,V}
done  output  1  one-cycle pulse when c_out/status updated

Behaviour:
- Reset (async): state=IDLE; A, B, C, status, captured fields, rd_num, aluop all 0; ready=1, done=0.
- FSM states and transitions (one transition per clk edge):
  - IDLE -> RD_A on start=1; instruction fields captured at that edge. start=0 stays IDLE.
  - RD_A: rd_num=rn; A<=rd_data at exit edge; -> RD_B.
  - RD_B: rd_num=rm; B<=rd_data at exit edge; -> EXEC.
  - EXEC: C<=alu_out and status<=flags at exit edge; -> DONE.
  - DONE: done=1; -> IDLE.
- Latency: done is high in the 4th cycle after the accepting edge; the next start is accepted at the edge leaving DONE+1 (i.e. in IDLE).
- start while not in IDLE is ignored; it is not queued.
- rd_num = rn in RD_A, rm in RD_B, 0 otherwise.
- Shifter (combinational on B), sB:
  - 00: B
  - 01: B<<1, LSB 0
  - 10: B>>1, MSB 0
  - 11: B>>1, MSB = B[15]
- ALU operand drive: ain = asel ? 0 : A; bin = bsel ? sximm5 : sB. Driven continuously; only the EXEC values matter.
- Flags: status[2]=Z, [1]=N taken from alu_z.
  - status[0]=alu_z[0] for aluop 00/01.
  - status[0] forced to 0 for aluop 10/11, because the ALU V flag is undefined there.
- c_out and status hold their values until the next EXEC exit edge or reset.
- Reset mid-operation: immediate return to IDLE with all registers cleared; no done pulse.

Optional Feature:
- Macro: OPSTAGE_SKIP_A_EN.
- Defined: when the captured asel=1, IDLE -> RD_B directly, skipping RD_A; A is left unchanged; done arrives 3 cycles after the accepting edge.
- Undefined: RD_A is always visited; latency is always 4.

Test Plan:
- ADD: rn=1 (rd_data=0x0005), rm=2 (rd_data=0x0003), shift=00, aluop=00 -> c_out=0x0008, status=000, done 4 cycles after start, rd_num sequence 1,2.
- SUB equal: A=0x0007, B=0x0007, aluop=01 -> c_out=0x0000, status=100.
- ADD overflow: A=0x7FFF, B=0x0001, aluop=00 -> c_out=0x8000, status=011.
- MVN with shift: asel=1, B=0x0001, shift=01, aluop=11 -> bin=0x0002, c_out=0xFFFD, status=010 (V cleared). With OPSTAGE_SKIP_A_EN, done arrives 3 cycles after start.
- Arithmetic right: B=0x8004, shift=11, bsel=0, asel=1, aluop=00 -> c_out=0xC002, status=010.
- Reset asserted during RD_B after a prior result of 0x0008 -> c_out=0, status=000, ready=1 immediately, no done. Also: a start pulse during EXEC is ignored.
